// File: rtl/hazard_stall_unit.sv
// Stalls/squashes the pipeline for load-use and MDU hazards; outputs are combinational (0 cycles).
// Backpressure: holds PC and IF/ID while a hazard is live; a taken branch overrides the stall.
module hazard_stall_unit #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFID_RegRs,
    input  logic [4:0]       IFID_RegRt,
    input  logic             IFID_UsesRt,
    input  logic             IFID_HiLoUse,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_RegRt,
    input  logic             IDEX_MduStart,
    input  logic             BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             MduBusy,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int CW = $clog2(MDU_LATENCY) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic          loadUse, mduHaz, stall;

    assign loadUse = IDEX_MemRead && (IDEX_RegRt != 5'd0) &&
                     ((IDEX_RegRt == IFID_RegRs) ||
                      (IFID_UsesRt && (IDEX_RegRt == IFID_RegRt)));
    assign mduHaz  = IFID_HiLoUse && (IDEX_MduStart || (state == BUSY));
    // A taken branch squashes the waiting ID op, so there is nothing to stall.
    assign stall   = (loadUse || mduHaz) && !BranchTaken;

    assign PCWrite     = !stall;
    assign IFIDWrite   = !stall;
    assign IDEX_Bubble = stall || BranchTaken;
    assign IFID_Flush  = BranchTaken;
    assign MduBusy     = (state == BUSY);

    // The issued MDU op always runs to completion; new issues while BUSY are ignored.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (IDEX_MduStart && (MDU_LATENCY > 1)) begin
                    stateNext = BUSY;
                    cntNext   = CW'(MDU_LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt == CW'(1)) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt - CW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
        end else if (stall && (StallCycles != {CNT_W{1'b1}})) begin
            StallCycles <= StallCycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: default DUT plus a CNT_W=4 / MDU_LATENCY=1 DUT driven by the same inputs.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs, rt, exRt;
    logic        usesRt, hiLoUse, memRead, mduStart, branch;

    logic        pcWrite, ifidWrite, bubble, flush, mduBusy;
    logic [15:0] stallCycles;
    logic        sPcWrite, sIfidWrite, sBubble, sFlush, sMduBusy;
    logic [3:0]  sStallCycles;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MDU_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_RegRs(rs), .IFID_RegRt(rt), .IFID_UsesRt(usesRt), .IFID_HiLoUse(hiLoUse),
        .IDEX_MemRead(memRead), .IDEX_RegRt(exRt), .IDEX_MduStart(mduStart),
        .BranchTaken(branch),
        .PCWrite(pcWrite), .IFIDWrite(ifidWrite), .IDEX_Bubble(bubble),
        .IFID_Flush(flush), .MduBusy(mduBusy), .StallCycles(stallCycles)
    );

    hazard_stall_unit #(.MDU_LATENCY(1), .CNT_W(4)) dutSmall (
        .clk(clk), .rst_n(rst_n),
        .IFID_RegRs(rs), .IFID_RegRt(rt), .IFID_UsesRt(usesRt), .IFID_HiLoUse(hiLoUse),
        .IDEX_MemRead(memRead), .IDEX_RegRt(exRt), .IDEX_MduStart(mduStart),
        .BranchTaken(branch),
        .PCWrite(sPcWrite), .IFIDWrite(sIfidWrite), .IDEX_Bubble(sBubble),
        .IFID_Flush(sFlush), .MduBusy(sMduBusy), .StallCycles(sStallCycles)
    );

    task automatic clearIn();
        rs = 5'd0; rt = 5'd0; exRt = 5'd0;
        usesRt = 1'b0; hiLoUse = 1'b0; memRead = 1'b0; mduStart = 1'b0; branch = 1'b0;
    endtask

    // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        clearIn();
        #3;
        nChecks++;
        if ({pcWrite, ifidWrite, bubble, flush} !== 4'b1100)
            $display("FAIL reset_ctrl: got %b want 1100", {pcWrite, ifidWrite, bubble, flush});
        else nPass++;
        nChecks++;
        if (mduBusy !== 1'b0 || stallCycles !== 16'd0)
            $display("FAIL reset_state: busy=%b cnt=%0d want busy=0 cnt=0", mduBusy, stallCycles);
        else nPass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        memRead = 1'b1; exRt = 5'd8; rs = 5'd8;
        #1;
        nChecks++;
        if ({pcWrite, ifidWrite, bubble, flush} !== 4'b0010)
            $display("FAIL loaduse_ctrl: got %b want 0010", {pcWrite, ifidWrite, bubble, flush});
        else nPass++;
        tick();
        clearIn();
        #1;
        nChecks++;
        if (stallCycles !== 16'd1 || pcWrite !== 1'b1 || bubble !== 1'b0)
            $display("FAIL loaduse_after: cnt=%0d pc=%b bub=%b want 1 1 0", stallCycles, pcWrite, bubble);
        else nPass++;
    endtask

    task automatic test_no_stall();
        memRead = 1'b1; exRt = 5'd0; rs = 5'd0;
        #1;
        nChecks++;
        if (pcWrite !== 1'b1 || bubble !== 1'b0)
            $display("FAIL zero_reg: pc=%b bub=%b want 1 0", pcWrite, bubble);
        else nPass++;
        exRt = 5'd9; rt = 5'd9; rs = 5'd3; usesRt = 1'b0;
        #1;
        nChecks++;
        if (pcWrite !== 1'b1)
            $display("FAIL rt_unused: pc=%b want 1", pcWrite);
        else nPass++;
        usesRt = 1'b1;
        #1;
        nChecks++;
        if (pcWrite !== 1'b0 || ifidWrite !== 1'b0)
            $display("FAIL rt_used: pc=%b ifid=%b want 0 0", pcWrite, ifidWrite);
        else nPass++;
        clearIn();
        tick();
        nChecks++;
        if (stallCycles !== 16'd1)
            $display("FAIL nostall_cnt: got %0d want 1", stallCycles);
        else nPass++;
    endtask

    task automatic test_mdu();
        mduStart = 1'b1; hiLoUse = 1'b1;
        #1;
        nChecks++;
        if (pcWrite !== 1'b0 || mduBusy !== 1'b0)
            $display("FAIL mdu_issue: pc=%b busy=%b want 0 0", pcWrite, mduBusy);
        else nPass++;
        tick();
        mduStart = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            mduStart = (k == 2);
            #1;
            nChecks++;
            if (pcWrite !== 1'b0 || mduBusy !== 1'b1)
                $display("FAIL mdu_busy_%0d: pc=%b busy=%b want 0 1", k, pcWrite, mduBusy);
            else nPass++;
            tick();
        end
        mduStart = 1'b0;
        #1;
        nChecks++;
        if (pcWrite !== 1'b1 || mduBusy !== 1'b0 || stallCycles !== 16'd5)
            $display("FAIL mdu_done: pc=%b busy=%b cnt=%0d want 1 0 5", pcWrite, mduBusy, stallCycles);
        else nPass++;
        nChecks++;
        if (sMduBusy !== 1'b0 || sStallCycles !== 4'd3)
            $display("FAIL lat1_mdu: busy=%b cnt=%0d want 0 3", sMduBusy, sStallCycles);
        else nPass++;
        clearIn();
        tick();
    endtask

    task automatic test_branch();
        memRead = 1'b1; exRt = 5'd8; rs = 5'd8; branch = 1'b1;
        #1;
        nChecks++;
        if ({pcWrite, ifidWrite, bubble, flush} !== 4'b1111)
            $display("FAIL branch_ctrl: got %b want 1111", {pcWrite, ifidWrite, bubble, flush});
        else nPass++;
        clearIn();
        mduStart = 1'b1;
        tick();
        mduStart = 1'b0; branch = 1'b1; hiLoUse = 1'b1;
        #1;
        nChecks++;
        if (mduBusy !== 1'b1 || pcWrite !== 1'b1 || stallCycles !== 16'd5)
            $display("FAIL branch_busy: busy=%b pc=%b cnt=%0d want 1 1 5", mduBusy, pcWrite, stallCycles);
        else nPass++;
        tick();
        tick();
        #1;
        nChecks++;
        if (mduBusy !== 1'b1)
            $display("FAIL branch_busy_last: busy=%b want 1", mduBusy);
        else nPass++;
        tick();
        #1;
        nChecks++;
        if (mduBusy !== 1'b0 || stallCycles !== 16'd5)
            $display("FAIL branch_countdown: busy=%b cnt=%0d want 0 5", mduBusy, stallCycles);
        else nPass++;
        clearIn();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        mduStart = 1'b1;
        tick();
        mduStart = 1'b0;
        tick();
        #1;
        nChecks++;
        if (mduBusy !== 1'b1)
            $display("FAIL pre_reset_busy: got %b want 1", mduBusy);
        else nPass++;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (mduBusy !== 1'b0 || stallCycles !== 16'd0)
            $display("FAIL async_reset: busy=%b cnt=%0d want 0 0", mduBusy, stallCycles);
        else nPass++;
        #1;
        rst_n = 1'b1;
        tick();
        hiLoUse = 1'b1;
        #1;
        nChecks++;
        if (pcWrite !== 1'b1 || mduBusy !== 1'b0)
            $display("FAIL post_reset_mflo: pc=%b busy=%b want 1 0", pcWrite, mduBusy);
        else nPass++;
        clearIn();
        tick();
    endtask

    task automatic test_saturate();
        memRead = 1'b1; exRt = 5'd8; rs = 5'd8;
        repeat (15) tick();
        nChecks++;
        if (sStallCycles !== 4'd15)
            $display("FAIL sat_reach: got %0d want 15", sStallCycles);
        else nPass++;
        repeat (5) tick();
        nChecks++;
        if (sStallCycles !== 4'd15 || stallCycles !== 16'd20)
            $display("FAIL sat_hold: small=%0d big=%0d want 15 20", sStallCycles, stallCycles);
        else nPass++;
        clearIn();
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_mdu();
        test_branch();
        test_reset_mid_busy();
        test_saturate();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
